// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - two-requester nibble-serial adder sharing one 4-bit lookahead adder
module fourbitfulladderNonRipple (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // every carry is a flat sum-of-products of g/p/cin, so no carry ripples through stages
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, rr, id_reg;
    logic             grant, accept, last_nib;
    logic [3:0]       add_a, add_b, add_sum;
    logic             add_cout;

    // with both or neither requester valid, the round-robin pointer decides
    always_comb begin
        grant = rr;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = !rst && (state == IDLE) && !grant;
    assign req1_ready = !rst && (state == IDLE) && grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign last_nib   = (cnt == CW'(NIB - 1));

    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        sum_nxt = sum_reg;
        for (int i = 0; i < NIB; i++) begin
            if (cnt == CW'(i)) begin
                add_a               = a_reg[4*i +: 4];
                add_b               = b_reg[4*i +: 4];
                sum_nxt[4*i +: 4]   = add_sum;
            end
        end
    end

    fourbitfulladderNonRipple u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:    if (last_nib)  state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            rr       <= 1'b0;
            id_reg   <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_id   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg  <= grant ? req1_a : req0_a;
                        b_reg  <= grant ? req1_b : req0_b;
                        carry  <= grant ? req1_cin : req0_cin;
                        id_reg <= grant;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    sum_reg <= sum_nxt;
                    carry   <= add_cout;
                    cnt     <= cnt + 1'b1;
                    // result registers only move here, so they hold steady through DONE and IDLE
                    if (last_nib) begin
                        cnt      <= '0;
                        res_sum  <= sum_nxt;
                        res_cout <= add_cout;
                        res_id   <= id_reg;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        rr <= ~res_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - scoreboard bench for nibble_serial_add_ctrl at WIDTH 16 and 8
module tb_nibble_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        id;
        int          cyc;
    } exp_t;

    // WIDTH=16 instance signals
    logic        w_v0, w_rdy0, w_c0, w_v1, w_rdy1, w_c1;
    logic [15:0] w_a0, w_b0, w_a1, w_b1, w_sum;
    logic        w_rv, w_rr, w_cout, w_id, w_busy;
    // WIDTH=8 instance signals
    logic        n_v0, n_rdy0, n_c0, n_v1, n_rdy1, n_c1;
    logic [7:0]  n_a0, n_b0, n_a1, n_b1, n_sum;
    logic        n_rv, n_rr, n_cout, n_id, n_busy;

    nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .req0_valid(w_v0), .req0_ready(w_rdy0), .req0_a(w_a0), .req0_b(w_b0), .req0_cin(w_c0),
        .req1_valid(w_v1), .req1_ready(w_rdy1), .req1_a(w_a1), .req1_b(w_b1), .req1_cin(w_c1),
        .res_valid(w_rv), .res_ready(w_rr), .res_sum(w_sum), .res_cout(w_cout), .res_id(w_id),
        .busy(w_busy)
    );

    nibble_serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .req0_valid(n_v0), .req0_ready(n_rdy0), .req0_a(n_a0), .req0_b(n_b0), .req0_cin(n_c0),
        .req1_valid(n_v1), .req1_ready(n_rdy1), .req1_a(n_a1), .req1_b(n_b1), .req1_cin(n_c1),
        .res_valid(n_rv), .res_ready(n_rr), .res_sum(n_sum), .res_cout(n_cout), .res_id(n_id),
        .busy(n_busy)
    );

    exp_t q16[$];
    exp_t q8[$];
    logic ids16[$];
    bit   rr16, rr8;
    int   acc16 = 0, acc8 = 0, res8 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // acceptance side: the reference result is A+B+cin, pushed at the handshake
    exp_t        e16a, e8a;
    logic [16:0] s16;
    logic [8:0]  s8;
    logic        g16, g8;

    always @(negedge clk) begin
        if (!rst) begin
            check("ready_excl16", {31'd0, w_rdy0 & w_rdy1}, 0);
            if (q16.size() != 0) check("ready_busy16", {31'd0, w_rdy0 | w_rdy1}, 0);
            if ((w_v0 && w_rdy0) || (w_v1 && w_rdy1)) begin
                g16 = w_v1 && w_rdy1;
                check("grant16", {31'd0, g16}, {31'd0, (w_v0 && w_v1) ? rr16 : w_v1});
                s16 = g16 ? ({1'b0, w_a1} + {1'b0, w_b1} + 17'(w_c1))
                          : ({1'b0, w_a0} + {1'b0, w_b0} + 17'(w_c0));
                e16a.sum = s16[15:0]; e16a.cout = s16[16]; e16a.id = g16; e16a.cyc = cyc;
                q16.push_back(e16a);
                ids16.push_back(g16);
                acc16++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("ready_excl8", {31'd0, n_rdy0 & n_rdy1}, 0);
            if (q8.size() != 0) check("ready_busy8", {31'd0, n_rdy0 | n_rdy1}, 0);
            if ((n_v0 && n_rdy0) || (n_v1 && n_rdy1)) begin
                g8 = n_v1 && n_rdy1;
                check("grant8", {31'd0, g8}, {31'd0, (n_v0 && n_v1) ? rr8 : n_v1});
                s8 = g8 ? ({1'b0, n_a1} + {1'b0, n_b1} + 9'(n_c1))
                        : ({1'b0, n_a0} + {1'b0, n_b0} + 9'(n_c0));
                e8a.sum = {8'h00, s8[7:0]}; e8a.cout = s8[8]; e8a.id = g8; e8a.cyc = cyc;
                q8.push_back(e8a);
                acc8++;
            end
        end
    end

    // result side: pops and compares whenever a result is handed over
    exp_t        e16m, e8m;
    logic        pv16, pr16, pc16, pi16, pv8, pr8, pc8, pi8;
    logic [15:0] ps16;
    logic [7:0]  ps8;

    always @(negedge clk) begin
        if (rst) begin
            pv16 = 1'b0; rr16 = 1'b0; q16.delete();
        end else begin
            if (w_rv && !pv16) begin
                if (q16.size() == 0) check("spurious16", 1, 0);
                else check("latency16", cyc - q16[0].cyc, 5);
            end
            if (w_rv && pv16 && !pr16) begin
                check("hold_sum16", {16'd0, w_sum}, {16'd0, ps16});
                check("hold_cout16", {31'd0, w_cout}, {31'd0, pc16});
                check("hold_id16", {31'd0, w_id}, {31'd0, pi16});
            end
            if (w_rv && w_rr) begin
                if (q16.size() == 0) check("spurious16", 1, 0);
                else begin
                    e16m = q16.pop_front();
                    check("sum16", {16'd0, w_sum}, {16'd0, e16m.sum});
                    check("cout16", {31'd0, w_cout}, {31'd0, e16m.cout});
                    check("id16", {31'd0, w_id}, {31'd0, e16m.id});
                    rr16 = ~e16m.id;
                end
            end
            pv16 = w_rv; pr16 = w_rr; ps16 = w_sum; pc16 = w_cout; pi16 = w_id;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pv8 = 1'b0; rr8 = 1'b0; q8.delete();
        end else begin
            if (n_rv && !pv8) begin
                if (q8.size() == 0) check("spurious8", 1, 0);
                else check("latency8", cyc - q8[0].cyc, 3);
            end
            if (n_rv && pv8 && !pr8) begin
                check("hold_sum8", {24'd0, n_sum}, {24'd0, ps8});
                check("hold_cout8", {31'd0, n_cout}, {31'd0, pc8});
                check("hold_id8", {31'd0, n_id}, {31'd0, pi8});
            end
            if (n_rv && n_rr) begin
                if (q8.size() == 0) check("spurious8", 1, 0);
                else begin
                    e8m = q8.pop_front();
                    check("sum8", {24'd0, n_sum}, {16'd0, e8m.sum});
                    check("cout8", {31'd0, n_cout}, {31'd0, e8m.cout});
                    check("id8", {31'd0, n_id}, {31'd0, e8m.id});
                    rr8 = ~e8m.id;
                    res8++;
                end
            end
            pv8 = n_rv; pr8 = n_rr; ps8 = n_sum; pc8 = n_cout; pi8 = n_id;
        end
    end

    task automatic issue16(input bit id, input logic [15:0] a, input logic [15:0] b, input logic c);
        bit done = 1'b0;
        if (id) begin w_v1 = 1'b1; w_a1 = a; w_b1 = b; w_c1 = c; end
        else    begin w_v0 = 1'b1; w_a0 = a; w_b0 = b; w_c0 = c; end
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            done = id ? (w_rdy1 === 1'b1) : (w_rdy0 === 1'b1);
            @(posedge clk); #1;
        end
        check("issue16_accept", {31'd0, done}, 1);
        w_v0 = 1'b0; w_v1 = 1'b0;
        w_a0 = 16'($urandom); w_b0 = 16'($urandom); w_a1 = 16'($urandom); w_b1 = 16'($urandom);
    endtask

    task automatic drain16();
        for (int t = 0; t < 200 && q16.size() != 0; t++) @(posedge clk);
        #1;
        check("drain16", q16.size(), 0);
    endtask

    int base, tgt;

    initial begin
        rst = 1'b1;
        {w_v0, w_c0, w_v1, w_c1, n_v0, n_c0, n_v1, n_c1} = '0;
        {w_a0, w_b0, w_a1, w_b1} = '0;
        {n_a0, n_b0, n_a1, n_b1} = '0;
        w_rr = 1'b1; n_rr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, w_rv}, 0);
        check("rst_busy", {31'd0, w_busy}, 0);
        check("rst_sum", {16'd0, w_sum}, 0);
        check("rst_cout_id", {30'd0, w_cout, w_id}, 0);
        check("rst_ready", {30'd0, w_rdy0, w_rdy1}, 0);
        rst = 1'b0;
        #1;
        check("rr_reset_ready0", {30'd0, w_rdy0, w_rdy1}, 32'h2);

        issue16(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        drain16();
        check("dir1_result", {15'd0, w_cout, w_sum}, 32'h10000);
        check("dir1_id", {31'd0, w_id}, 0);
        issue16(1'b1, 16'h0F0F, 16'h00F1, 1'b1);
        drain16();
        check("dir2_result", {15'd0, w_cout, w_sum}, 32'h01001);
        check("dir2_id", {31'd0, w_id}, 1);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        base = ids16.size();
        tgt  = acc16 + 4;
        w_a0 = 16'h1357; w_b0 = 16'h2468; w_c0 = 1'b1;
        w_a1 = 16'hABCD; w_b1 = 16'h1111; w_c1 = 1'b0;
        w_v0 = 1'b1; w_v1 = 1'b1;
        for (int t = 0; t < 200 && acc16 < tgt; t++) @(posedge clk);
        #1;
        w_v0 = 1'b0; w_v1 = 1'b0;
        drain16();
        check("rr_count", ids16.size() - base, 4);
        for (int k = 0; k < 4 && base + k < ids16.size(); k++)
            check("rr_order", {31'd0, ids16[base+k]}, k % 2);

        w_rr = 1'b0;
        issue16(1'b1, 16'hBEEF, 16'h1234, 1'b1);
        for (int t = 0; t < 20 && w_rv !== 1'b1; t++) @(negedge clk);
        check("hold_reach", {31'd0, w_rv}, 1);
        repeat (10) begin
            @(negedge clk);
            check("hold_valid", {31'd0, w_rv}, 1);
        end
        check("hold_result", {15'd0, w_cout, w_sum}, 32'h0D124);
        @(posedge clk); #1 w_rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_take", {31'd0, w_busy}, 0);

        issue16(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, w_rv}, 0);
        check("midrst_busy", {31'd0, w_busy}, 0);
        check("midrst_sum", {16'd0, w_sum}, 0);
        check("midrst_cout_id", {30'd0, w_cout, w_id}, 0);
        check("midrst_ready", {30'd0, w_rdy0, w_rdy1}, 0);
        @(posedge clk); #1 rst = 1'b0;
        issue16(1'b0, 16'h1234, 16'h4321, 1'b0);
        drain16();
        check("post_rst_result", {15'd0, w_cout, w_sum}, 32'h05555);

        for (int t = 0; t < 60000 && acc8 < 2000; t++) begin
            n_v0 = 1'($urandom_range(0, 1)); n_v1 = 1'($urandom_range(0, 1));
            n_a0 = 8'($urandom); n_b0 = 8'($urandom); n_c0 = 1'($urandom_range(0, 1));
            n_a1 = 8'($urandom); n_b1 = 8'($urandom); n_c1 = 1'($urandom_range(0, 1));
            n_rr = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        n_v0 = 1'b0; n_v1 = 1'b0; n_rr = 1'b1;
        for (int t = 0; t < 200 && q8.size() != 0; t++) @(posedge clk);
        #1;
        check("accepted8", acc8, 2000);
        check("results8", res8, 2000);
        check("drain8", q8.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
